uart_io_ctrl: RTL and testbench

Memory-mapped controller that sits between the CPU memory stage and the UART, replacing direct single-byte UART access with buffered transmit and receive queues. It decodes the UART I/O address window, returns status and receive data to the load path, and queues store data for transmit. It stalls the pipeline only when software writes into a full transmit queue. It drains and fills both queues autonomously through ready/valid handshakes with the UART.

---
 rtl/uart_io_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_io_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_ctrl
// Description : Memory-mapped UART controller between the CPU memory stage
//               and the UART. Stores to the TX data address are queued and
//               drained to the transmitter through a ready/valid handshake;
//               bytes from the receiver are queued and returned to loads.
//               The pipeline is stalled only for a store into a full TX
//               queue.
// Ports       : clk          - rising-edge clock
//               reset        - asynchronous active-high reset
//               Address      - memory-stage byte address
//               MemRead      - load strobe
//               MemWrite     - store strobe
//               WriteData    - store data (low byte)
//               ReadData     - load result for UART addresses, else 0
//               Stall        - current store has not been accepted
//               DataIn       - byte to UART transmitter
//               DataInValid  - DataIn is valid
//               DataInReady  - transmitter accepts DataIn
//               DataOut      - byte from UART receiver
//               DataOutValid - DataOut is valid
//               DataOutReady - controller accepts DataOut
// Address map : 0x80000000 R  bit0 = TX queue not full
//               0x80000004 R  bit0 = RX queue not empty
//               0x80000008 W  push WriteData into TX queue
//               0x8000000C R  bits[7:0] = RX head, pops RX queue
//               0x80000010 R  bits[7:0] = tx_count, bits[15:8] = rx_count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_io_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [7:0]  WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  localparam logic [c_cw-1:0] c_full    = DEPTH[c_cw-1:0];
  localparam logic [c_cw-1:0] c_cnt_one = {{(c_cw-1){1'b0}}, 1'b1};
  localparam logic [c_aw-1:0] c_ptr_one = {{(c_aw-1){1'b0}}, 1'b1};

  localparam logic [31:0] c_addr_tx_stat = 32'h8000_0000;
  localparam logic [31:0] c_addr_rx_stat = 32'h8000_0004;
  localparam logic [31:0] c_addr_tx_data = 32'h8000_0008;
  localparam logic [31:0] c_addr_rx_data = 32'h8000_000C;
  localparam logic [31:0] c_addr_counts  = 32'h8000_0010;

  // Queue storage and bookkeeping
  logic [7:0]      r_tx_mem [DEPTH];
  logic [c_aw-1:0] r_tx_wp;
  logic [c_aw-1:0] r_tx_rp;
  logic [c_cw-1:0] r_tx_cnt;

  logic [7:0]      r_rx_mem [DEPTH];
  logic [c_aw-1:0] r_rx_wp;
  logic [c_aw-1:0] r_rx_rp;
  logic [c_cw-1:0] r_rx_cnt;

  // Internal handshake terms are kept free of the reset net; only the
  // outputs are masked while reset is held so nothing leaks to the pipeline
  // or the UART during reset.
  logic w_tx_full;
  logic w_tx_nempty;
  logic w_rx_full;
  logic w_rx_nempty;
  logic w_tx_wr_sel;
  logic w_stall;
  logic w_tx_push;
  logic w_tx_pop;
  logic w_rx_push;
  logic w_rx_pop;
  logic [7:0] w_tx_cnt8;
  logic [7:0] w_rx_cnt8;
  logic [31:0] w_rdata;

  assign w_tx_full   = (r_tx_cnt == c_full);
  assign w_tx_nempty = (r_tx_cnt != '0);
  assign w_rx_full   = (r_rx_cnt == c_full);
  assign w_rx_nempty = (r_rx_cnt != '0);

  // Only the write strobe decodes the TX data address, so a simultaneous
  // load to the same address cannot pop or corrupt the RX queue.
  assign w_tx_wr_sel = MemWrite && (Address == c_addr_tx_data);

  // Stall uses the registered count: a UART pop in the same cycle does not
  // let a store into a full queue through until the following cycle.
  assign w_stall   = w_tx_wr_sel && w_tx_full;
  assign w_tx_push = w_tx_wr_sel && !w_stall;
  assign w_tx_pop  = w_tx_nempty && DataInReady;

  assign w_rx_push = DataOutValid && !w_rx_full;
  assign w_rx_pop  = MemRead && (Address == c_addr_rx_data) && w_rx_nempty;

  // Outputs
  assign Stall        = w_stall && !reset;
  assign DataInValid  = w_tx_nempty && !reset;
  assign DataIn       = DataInValid ? r_tx_mem[r_tx_rp] : 8'h00;
  assign DataOutReady = !w_rx_full && !reset;

  // TX queue bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + c_ptr_one;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_ptr_one;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + c_cnt_one;
        2'b01:   r_tx_cnt <= r_tx_cnt - c_cnt_one;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // RX queue bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + c_ptr_one;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_ptr_one;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + c_cnt_one;
        2'b01:   r_rx_cnt <= r_rx_cnt - c_cnt_one;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Queue contents need no reset; the counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= DataOut;
  end

  // Load path
  assign w_tx_cnt8 = 8'(r_tx_cnt);
  assign w_rx_cnt8 = 8'(r_rx_cnt);

  always_comb begin
    w_rdata = 32'h0000_0000;
    if (MemRead && !reset) begin
      case (Address)
        c_addr_tx_stat: w_rdata[0] = !w_tx_full;
        c_addr_rx_stat: w_rdata[0] = w_rx_nempty;
        c_addr_rx_data: if (w_rx_nempty) w_rdata[7:0] = r_rx_mem[r_rx_rp];
        c_addr_counts:  w_rdata[15:0] = {w_rx_cnt8, w_tx_cnt8};
        default:        w_rdata = 32'h0000_0000;
      endcase
    end
  end

  assign ReadData = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_io_ctrl
// Description : Self-checking bench for uart_io_ctrl. Stimulus pushes the
//               expected load results and transmitted bytes into queues; a
//               monitor compares them whenever the DUT presents a load or a
//               TX handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_io_ctrl;

  localparam logic [31:0] c_tx_stat = 32'h8000_0000;
  localparam logic [31:0] c_rx_stat = 32'h8000_0004;
  localparam logic [31:0] c_tx_data = 32'h8000_0008;
  localparam logic [31:0] c_rx_data = 32'h8000_000C;
  localparam logic [31:0] c_counts  = 32'h8000_0010;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic [7:0]  DataIn;
  logic        DataInValid;
  logic        DataInReady;
  logic [7:0]  DataOut;
  logic        DataOutValid;
  logic        DataOutReady;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  string       nm_q  [$];
  logic [7:0]  tx_q  [$];

  logic [31:0] mon_e;
  string       mon_n;
  logic [7:0]  mon_b;

  uart_io_ctrl #(.DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Stall        (Stall),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    Address = a;
    MemRead = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(n);
    step();
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    Address   = c_tx_data;
    MemWrite  = 1'b1;
    WriteData = d;
    tx_q.push_back(d);
    step();
    MemWrite = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    DataOut      = d;
    DataOutValid = 1'b1;
    step();
    DataOutValid = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a load result or
  // completes a TX handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (MemRead) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got %h required no load", ReadData);
        end else begin
          mon_e = exp_q.pop_front();
          mon_n = nm_q.pop_front();
          if (ReadData !== mon_e) begin
            errors++;
            $display("FAIL %s: got %h required %h", mon_n, ReadData, mon_e);
          end
        end
      end
      if (DataInValid && DataInReady) begin
        checks++;
        if (tx_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx: got %h required no transfer", DataIn);
        end else begin
          mon_b = tx_q.pop_front();
          if (DataIn !== mon_b) begin
            errors++;
            $display("FAIL tx_byte: got %h required %h", DataIn, mon_b);
          end
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    Address      = c_tx_stat;
    MemRead      = 1'b1;
    MemWrite     = 1'b0;
    WriteData    = 8'h00;
    DataInReady  = 1'b0;
    DataOut      = 8'h00;
    DataOutValid = 1'b0;

    // Reset state
    #12;
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_stall", {31'h0, Stall}, 32'h0);
    chk("rst_dinvalid", {31'h0, DataInValid}, 32'h0);
    chk("rst_doutready", {31'h0, DataOutReady}, 32'h0);
    chk("rst_datain", {24'h0, DataIn}, 32'h0);
    MemRead = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_doutready", {31'h0, DataOutReady}, 32'h1);
    chk("post_rst_dinvalid", {31'h0, DataInValid}, 32'h0);
    step();
    rd(c_tx_stat, 32'h1, "tx_not_full_init");
    rd(c_rx_stat, 32'h0, "rx_not_empty_init");

    // Fill TX queue with the transmitter stalled
    for (int i = 0; i < 8; i++) begin
      Address   = c_tx_data;
      MemWrite  = 1'b1;
      WriteData = 8'h41 + 8'(i);
      tx_q.push_back(8'h41 + 8'(i));
      @(negedge clk);
      chk("tx_fill_stall", {31'h0, Stall}, 32'h0);
      if (i == 0) chk("tx_valid_before", {31'h0, DataInValid}, 32'h0);
      if (i == 1) chk("tx_valid_latency", {31'h0, DataInValid}, 32'h1);
      step();
    end
    MemWrite = 1'b0;
    rd(c_counts, 32'h0000_0008, "tx_count_full");
    rd(c_tx_stat, 32'h0, "tx_full_status");

    // Store into full queue stalls until a pop frees a slot
    Address   = c_tx_data;
    MemWrite  = 1'b1;
    WriteData = 8'h49;
    @(negedge clk);
    chk("stall_full", {31'h0, Stall}, 32'h1);
    step();
    DataInReady = 1'b1;
    @(negedge clk);
    chk("stall_during_pop", {31'h0, Stall}, 32'h1);
    step();
    DataInReady = 1'b0;
    @(negedge clk);
    chk("stall_release", {31'h0, Stall}, 32'h0);
    tx_q.push_back(8'h49);
    step();
    MemWrite = 1'b0;
    rd(c_counts, 32'h0000_0008, "tx_count_after_accept");

    // Drain with a bounded wait
    DataInReady = 1'b1;
    for (int k = 0; k < 20 && tx_q.size() != 0; k++) step();
    DataInReady = 1'b0;
    chk("tx_drain_done", tx_q.size(), 32'h0);
    tx_q.delete();
    @(negedge clk);
    chk("tx_valid_empty", {31'h0, DataInValid}, 32'h0);
    step();
    rd(c_counts, 32'h0, "counts_after_drain");

    // RX single byte; push not visible in the same cycle
    DataOut      = 8'h5A;
    DataOutValid = 1'b1;
    Address      = c_rx_stat;
    MemRead      = 1'b1;
    exp_q.push_back(32'h0);
    nm_q.push_back("rx_stat_same_cycle");
    step();
    DataOutValid = 1'b0;
    MemRead      = 1'b0;
    rd(c_rx_stat, 32'h1, "rx_stat_next_cycle");
    rd(c_rx_data, 32'h0000_005A, "rx_data_5a");
    rd(c_counts, 32'h0, "rx_count_after_pop");

    // Fill RX queue
    for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
    @(negedge clk);
    chk("rx_full_ready", {31'h0, DataOutReady}, 32'h0);
    step();
    rd(c_counts, 32'h0000_0800, "rx_count_full");

    // CPU pop while the UART holds a byte
    DataOut      = 8'h18;
    DataOutValid = 1'b1;
    Address      = c_rx_data;
    MemRead      = 1'b1;
    exp_q.push_back(32'h10);
    nm_q.push_back("rx_pop_while_full");
    step();
    MemRead = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_pop", {31'h0, DataOutReady}, 32'h1);
    step();
    DataOutValid = 1'b0;
    rd(c_counts, 32'h0000_0800, "rx_count_refilled");
    rd(c_rx_data, 32'h11, "rx_order_11");
    rd(c_rx_data, 32'h12, "rx_order_12");

    // Simultaneous RX push and pop below full
    DataOut      = 8'h19;
    DataOutValid = 1'b1;
    Address      = c_rx_data;
    MemRead      = 1'b1;
    exp_q.push_back(32'h13);
    nm_q.push_back("rx_order_13");
    step();
    DataOutValid = 1'b0;
    MemRead      = 1'b0;
    rd(c_counts, 32'h0000_0600, "rx_count_push_pop");
    for (int i = 0; i < 6; i++) rd(c_rx_data, 32'h14 + 32'(i), "rx_order_tail");

    // Empty pop and unmapped address
    rd(c_rx_data, 32'h0, "rx_empty_read");
    rd(c_rx_stat, 32'h0, "rx_empty_status");
    rd(c_counts, 32'h0, "counts_empty");
    rd(32'h1000_0000, 32'h0, "unmapped_read");
    rx_push(8'h77);
    rd(c_rx_data, 32'h77, "rx_ptr_intact");

    // TX bytes queued, including a store with both strobes
    wr(8'h61);
    wr(8'h62);
    Address   = c_tx_data;
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    WriteData = 8'h63;
    exp_q.push_back(32'h0);
    nm_q.push_back("rdwr_same_addr");
    tx_q.push_back(8'h63);
    step();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    rd(c_counts, 32'h0000_0003, "tx_count_three");
    for (int i = 0; i < 5; i++) wr(8'h64 + 8'(i));

    // Asynchronous reset while a store is stalled
    Address   = c_tx_data;
    MemWrite  = 1'b1;
    WriteData = 8'h69;
    #2;
    chk("stall_before_reset", {31'h0, Stall}, 32'h1);
    reset = 1'b1;
    #1;
    chk("reset_stall_drop", {31'h0, Stall}, 32'h0);
    chk("reset_dinvalid_drop", {31'h0, DataInValid}, 32'h0);
    chk("reset_doutready", {31'h0, DataOutReady}, 32'h0);
    tx_q.delete();
    step();
    MemWrite = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rerst_dinvalid", {31'h0, DataInValid}, 32'h0);
    chk("rerst_doutready", {31'h0, DataOutReady}, 32'h1);
    step();
    rd(c_counts, 32'h0, "counts_after_reset");
    rd(c_tx_stat, 32'h1, "tx_stat_after_reset");
    rd(c_rx_stat, 32'h0, "rx_stat_after_reset");

    step();
    chk("rd_expect_drained", exp_q.size(), 32'h0);
    chk("tx_expect_drained", tx_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
